// File: rtl/ksa_if.sv
// ksa_if: start/ready handshake plus S-memory bus for the ARC4 key schedule.
// en/key/rddata flow into ksa; rdy/addr/wrdata/wren flow out of it.
interface ksa_if;
  logic        en;
  logic        rdy;
  logic [23:0] key;
  logic [7:0]  addr;
  logic [7:0]  rddata;
  logic [7:0]  wrdata;
  logic        wren;

  modport master (
    output en, key, rddata,
    input  rdy, addr, wrdata, wren
  );

  modport slave (
    input  en, key, rddata,
    output rdy, addr, wrdata, wren
  );
endinterface

// File: rtl/ksa.sv
// ksa: ARC4 key schedule applied in place to a 256-byte S memory.
// Ports: clk, rst_n (sync, active-low), bus (ksa_if.slave: en/rdy/key/addr/rddata/wrdata/wren).
module ksa (
  input  logic clk,
  input  logic rst_n,
  ksa_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    RD_I,
    CALC_J,
    RD_J,
    LATCH_J,
    WR_I,
    WR_J
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] i_q, i_d;
  logic [7:0] j_q, j_d;
  logic [7:0] si_q, si_d;
  logic [7:0] sj_q, sj_d;
  logic [1:0] kidx_q, kidx_d;
  logic [7:0] key_byte;

  // Big-endian key byte select; kidx never reaches 3.
  always_comb begin
    key_byte = bus.key[7:0];
    unique case (kidx_q)
      2'd0:    key_byte = bus.key[23:16];
      2'd1:    key_byte = bus.key[15:8];
      default: key_byte = bus.key[7:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      i_q     <= 8'd0;
      j_q     <= 8'd0;
      si_q    <= 8'd0;
      sj_q    <= 8'd0;
      kidx_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      kidx_q  <= kidx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    si_d    = si_q;
    sj_d    = sj_q;
    kidx_d  = kidx_q;
    unique case (state_q)
      IDLE: begin
        if (bus.en) begin
          state_d = RD_I;
          i_d     = 8'd0;
          j_d     = 8'd0;
          kidx_d  = 2'd0;
        end
      end
      RD_I: state_d = CALC_J;
      CALC_J: begin
        si_d    = bus.rddata;
        j_d     = j_q + bus.rddata + key_byte;
        state_d = RD_J;
      end
      RD_J: state_d = LATCH_J;
      LATCH_J: begin
        sj_d    = bus.rddata;
        state_d = WR_I;
      end
      WR_I: state_d = WR_J;
      WR_J: begin
        if (i_q == 8'hFF) begin
          state_d = IDLE;
        end else begin
          i_d     = i_q + 8'd1;
          kidx_d  = (kidx_q == 2'd2) ? 2'd0 : kidx_q + 2'd1;
          state_d = RD_I;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs decode registered state only, so en never reaches them.
  always_comb begin
    bus.rdy    = 1'b0;
    bus.wren   = 1'b0;
    bus.addr   = 8'd0;
    bus.wrdata = 8'd0;
    unique case (state_q)
      IDLE: bus.rdy = 1'b1;
      RD_I: bus.addr = i_q;
      RD_J: bus.addr = j_q;
      WR_I: begin
        bus.addr   = i_q;
        bus.wrdata = sj_q;
        bus.wren   = 1'b1;
      end
      WR_J: begin
        bus.addr   = j_q;
        bus.wrdata = si_q;
        bus.wren   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ksa.sv
// tb_ksa: directed vectors and multi-cycle sequences for ksa.
// Models the S RAM and a software key schedule.
module tb_ksa;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  ksa_if bus();

  ksa dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  logic [7:0] mem [256];
  logic       do_init = 1'b0;

  always @(posedge clk) begin
    if (do_init) begin
      for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
    end else if (bus.wren === 1'b1) begin
      mem[bus.addr] <= bus.wrdata;
    end
    bus.rddata <= mem[bus.addr];
  end

  int         wren_cnt = 0;
  logic [7:0] wa[$];
  logic [7:0] wd[$];

  always @(negedge clk) begin
    if (bus.wren === 1'b1) begin
      wren_cnt++;
      wa.push_back(bus.addr);
      wd.push_back(bus.wrdata);
    end
  end

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  logic [7:0] ms [256];

  task automatic model_init();
    for (int k = 0; k < 256; k++) ms[k] = 8'(k);
  endtask

  task automatic model_run(input logic [23:0] k);
    logic [7:0] j, t, kb;
    j = 8'd0;
    for (int i = 0; i < 256; i++) begin
      if (i % 3 == 0) kb = k[23:16];
      else if (i % 3 == 1) kb = k[15:8];
      else kb = k[7:0];
      j = j + ms[i] + kb;
      t = ms[i];
      ms[i] = ms[j];
      ms[j] = t;
    end
  endtask

  task automatic init_s();
    @(negedge clk) do_init = 1'b1;
    @(negedge clk) do_init = 1'b0;
    model_init();
  endtask

  task automatic start(input logic [23:0] k, input bit hold);
    bus.key = k;
    wa.delete();
    wd.delete();
    wren_cnt = 0;
    @(negedge clk) bus.en = 1'b1;
    @(posedge clk);
    #1;
    chk("rdy_fall", {31'd0, bus.rdy}, 32'd0);
    if (!hold) bus.en = 1'b0;
  endtask

  task automatic wait_done(output int lat, input int pulse_at);
    lat = 0;
    while (lat < 3000) begin
      @(posedge clk);
      lat++;
      #1;
      if (lat == pulse_at) bus.en = 1'b1;
      if (lat == pulse_at + 1) bus.en = 1'b0;
      if (bus.rdy === 1'b1) break;
    end
  endtask

  task automatic compare_mem(input string name);
    int bad;
    int dup;
    bit seen [256];
    bad = 0;
    dup = 0;
    for (int k = 0; k < 256; k++) seen[k] = 1'b0;
    for (int k = 0; k < 256; k++) begin
      if (mem[k] !== ms[k]) bad++;
      if (seen[mem[k]]) dup++;
      seen[mem[k]] = 1'b1;
    end
    chk({name, "_bytes_bad"}, bad, 0);
    chk({name, "_perm_dups"}, dup, 0);
  endtask

  typedef struct {
    logic [23:0] key;
    logic [47:0] a;
    logic [47:0] d;
  } vec_t;

  vec_t vecs [3];

  initial begin
    int lat;
    int snap;
    vecs[0] = '{24'h000000,
                {8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd3},
                {8'd0, 8'd0, 8'd1, 8'd1, 8'd3, 8'd2}};
    vecs[1] = '{24'h000018,
                {8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd27},
                {8'd0, 8'd0, 8'd1, 8'd1, 8'h1B, 8'd2}};
    vecs[2] = '{24'h010203,
                {8'd0, 8'd1, 8'd1, 8'd3, 8'd2, 8'd8},
                {8'd1, 8'd0, 8'd3, 8'd0, 8'd8, 8'd2}};

    bus.en = 1'b0;
    bus.key = 24'd0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_rdy", {31'd0, bus.rdy}, 32'd1);
    chk("rst_wren", {31'd0, bus.wren}, 32'd0);
    chk("rst_addr", {24'd0, bus.addr}, 32'd0);
    chk("rst_wrdata", {24'd0, bus.wrdata}, 32'd0);
    rst_n = 1'b1;
    wren_cnt = 0;
    repeat (20) @(posedge clk);
    #1;
    chk("idle_no_wren", wren_cnt, 0);
    chk("idle_rdy", {31'd0, bus.rdy}, 32'd1);

    for (int v = 0; v < 3; v++) begin
      init_s();
      model_run(vecs[v].key);
      start(vecs[v].key, 1'b0);
      wait_done(lat, 300);
      chk("latency", lat, 1536);
      chk("wren_cycles", wren_cnt, 512);
      for (int w = 0; w < 6; w++) begin
        chk("wr_addr", {24'd0, wa[w]}, {24'd0, vecs[v].a[47-8*w -: 8]});
        chk("wr_data", {24'd0, wd[w]}, {24'd0, vecs[v].d[47-8*w -: 8]});
      end
      compare_mem("final_s");
    end

    init_s();
    start(24'h000018, 1'b0);
    for (int c = 1; c < 700; c++) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_rdy", {31'd0, bus.rdy}, 32'd1);
    chk("midrst_wren", {31'd0, bus.wren}, 32'd0);
    snap = wren_cnt;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("midrst_no_writes", wren_cnt, snap);
    init_s();
    model_run(24'h000018);
    start(24'h000018, 1'b0);
    wait_done(lat, -10);
    chk("rerun_latency", lat, 1536);
    compare_mem("rerun_s");

    init_s();
    model_run(24'h000018);
    model_run(24'h000018);
    start(24'h000018, 1'b1);
    wait_done(lat, -10);
    chk("b2b_lat1", lat, 1536);
    @(posedge clk);
    #1;
    chk("b2b_restart", {31'd0, bus.rdy}, 32'd0);
    bus.en = 1'b0;
    wait_done(lat, -10);
    chk("b2b_lat2", lat, 1536);
    chk("b2b_wren", wren_cnt, 1024);
    compare_mem("b2b_s");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
